// File: rtl/ewb_queue.sv
// ewb_queue: multi-entry eviction write buffer between the L2 cache and
// physical memory.
//
// Dirty-line writebacks from upstream are absorbed into a circular FIFO of
// DEPTH line entries with a same-cycle response. A write to a line that is
// already buffered overwrites that entry instead of taking a new one. Reads
// that hit a buffered line are answered from the buffer; read misses go
// straight to memory. The buffer writes its oldest entry back to memory when
// a write arrives while it is full, after IDLE_CYCLES quiet cycles, or while
// flush is held.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   mem_read, mem_write      upstream request strobes, held until mem_resp
//   mem_address, mem_wdata   upstream line address / write data
//   mem_rdata, mem_resp      upstream read data / completion
//   flush                    level; drain continuously while high
//   pmem_read, pmem_write    memory request strobes, held until pmem_resp
//   pmem_address, pmem_wdata memory line address / write data
//   pmem_rdata, pmem_resp    memory read data / completion
//   count, empty, full       occupancy status
module ewb_queue #(
    parameter int DEPTH       = 4,
    parameter int LINE_W      = 256,
    parameter int ADDR_W      = 32,
    parameter int IDLE_CYCLES = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [ADDR_W-1:0]      mem_address,
    input  logic [LINE_W-1:0]      mem_wdata,
    output logic [LINE_W-1:0]      mem_rdata,
    output logic                   mem_resp,
    input  logic                   flush,
    output logic                   pmem_read,
    output logic                   pmem_write,
    output logic [ADDR_W-1:0]      pmem_address,
    output logic [LINE_W-1:0]      pmem_wdata,
    input  logic [LINE_W-1:0]      pmem_rdata,
    input  logic                   pmem_resp,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = $clog2(IDLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DEPTH-1:0]  valid;
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [LINE_W-1:0] data_mem [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [IW-1:0]     idle_cnt;

    logic              hit;
    logic [PW-1:0]     hit_idx;
    logic              do_enq;
    logic              do_coal;
    logic              do_pop;
    logic              idle_tick;
    logic              idle_done;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // idle_cnt holds the number of quiet cycles already completed, so the
    // current quiet cycle is the last one when it reaches IDLE_CYCLES-1.
    // That places the DRAIN entry IDLE_CYCLES+1 cycles after the last request.
    assign idle_done = (idle_cnt >= IW'(IDLE_CYCLES - 1));

    // Coalescing keeps addresses unique, so at most one entry can match.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (addr_mem[i] == mem_address)) begin
                hit     = 1'b1;
                hit_idx = PW'(i);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        mem_rdata    = '0;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        do_enq       = 1'b0;
        do_coal      = 1'b0;
        do_pop       = 1'b0;
        idle_tick    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_write) begin
                    if (hit) begin
                        do_coal  = 1'b1;
                        mem_resp = 1'b1;
                    end else if (!full) begin
                        do_enq   = 1'b1;
                        mem_resp = 1'b1;
                    end else begin
                        // Stall: make room first, accept on return to IDLE.
                        state_nxt = DRAIN;
                    end
                end else if (mem_read) begin
                    if (hit) begin
                        mem_rdata = data_mem[hit_idx];
                        mem_resp  = 1'b1;
                    end else begin
                        state_nxt = READ;
                    end
                end else if (!empty) begin
                    if (flush || idle_done) begin
                        state_nxt = DRAIN;
                    end else begin
                        idle_tick = 1'b1;
                    end
                end
            end
            READ: begin
                pmem_read    = 1'b1;
                pmem_address = mem_address;
                mem_rdata    = pmem_rdata;
                mem_resp     = pmem_resp;
                if (pmem_resp) begin
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                pmem_write   = 1'b1;
                pmem_address = addr_mem[head];
                pmem_wdata   = data_mem[head];
                // Writes wait (even to the head line, which is re-enqueued
                // after the pop); read hits are still served.
                if (mem_read && !mem_write && hit) begin
                    mem_rdata = data_mem[hit_idx];
                    mem_resp  = 1'b1;
                end
                if (pmem_resp) begin
                    do_pop    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            valid    <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            idle_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (do_enq) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PW'(1);
                count       <= count + CW'(1);
            end
            if (do_pop) begin
                valid[head] <= 1'b0;
                head        <= head + PW'(1);
                count       <= count - CW'(1);
            end
            if (!idle_tick) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IW'(IDLE_CYCLES)) begin
                idle_cnt <= idle_cnt + IW'(1);
            end
        end
    end

    // Line storage carries no reset; valid bits qualify every use.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            addr_mem[tail] <= mem_address;
            data_mem[tail] <= mem_wdata;
        end
        if (do_coal) begin
            data_mem[hit_idx] <= mem_wdata;
        end
    end

endmodule
